// File: rtl/tiny_acc_pkg.sv
// tiny_acc_pkg
//   Shared definitions for the tiny accumulator core: opcode values,
//   the NOP/HALT instruction encodings, instruction field positions,
//   the control state enum and a constant-foldable clog2 helper.
//   No ports (package).

package tiny_acc_pkg;

    // Instruction layout: op in the low nibble, arg in the high nibble.
    localparam int INST_W  = 8;
    localparam int OP_LSB  = 0;
    localparam int OP_W    = 4;
    localparam int ARG_LSB = 4;
    localparam int ARG_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_NAND = 4'h1;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
    localparam logic [OP_W-1:0] OP_BNZ  = 4'h3;
    localparam logic [OP_W-1:0] OP_LI   = 4'h4;
    localparam logic [OP_W-1:0] OP_SLLI = 4'h5;
    localparam logic [OP_W-1:0] OP_SRLI = 4'h6;
    localparam logic [OP_W-1:0] OP_HALT = 4'h7;
    localparam logic [OP_W-1:0] OP_LA   = 4'hE;
    localparam logic [OP_W-1:0] OP_SA   = 4'hF;

    localparam logic [INST_W-1:0] INST_NOP  = 8'h08;
    localparam logic [INST_W-1:0] INST_HALT = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Smallest r with 2**r >= v (v >= 2 in every use here).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tiny_acc_alu.sv
// tiny_acc_alu
//   Purely combinational execute-stage ALU. The result is both the next
//   accumulator value and the forwarded value that a BNZ in fetch tests.
//   Ports:
//     op_i       opcode of the instruction in execute
//     acc_i      current accumulator
//     operand_i  dmem[rs] (already 0 when rs is out of range)
//     sext_imm_i arg sign-extended to DATA_W; its low nibble is the shift amount
//     result_o   new accumulator value (acc_i for ops that do not write acc)

module tiny_acc_alu
    import tiny_acc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] operand_i,
    input  logic [DATA_W-1:0] sext_imm_i,
    output logic [DATA_W-1:0] result_o
);

    logic [ARG_W-1:0] shamt;
    logic             shamt_big;

    assign shamt     = sext_imm_i[ARG_W-1:0];
    // Shifting by the full width or more must give zero, not a wrapped shift.
    assign shamt_big = (32'(shamt) >= 32'(DATA_W));

    always_comb begin
        result_o = acc_i;
        case (op_i)
            OP_ADD:  result_o = acc_i + operand_i;
            OP_NAND: result_o = ~(acc_i & operand_i);
            OP_ADDI: result_o = acc_i + sext_imm_i;
            OP_LI:   result_o = sext_imm_i;
            OP_SLLI: result_o = shamt_big ? '0 : (acc_i << shamt);
            OP_SRLI: result_o = shamt_big ? '0 : (acc_i >> shamt);
            OP_LA:   result_o = operand_i;
            default: result_o = acc_i;
        endcase
    end

endmodule

// File: rtl/tiny_acc_core.sv
// tiny_acc_core
//   Two-stage accumulator processor: fetch/decode (imem[pc] -> IR) and
//   execute/writeback (IR -> acc / dmem). Control FSM IDLE/RUN/HALT with a
//   single-step mode and a runtime program-load port.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     prog_we/addr/data   imem write, honoured only when not in RUN
//     start               enter RUN from IDLE or HALT
//     step_mode, step     when step_mode=1, RUN advances only on step cycles
//     dbg_addr, dbg_data  combinational dmem read (0 when out of range)
//     acc_out, pc_out     accumulator and fetch PC
//     running, halted     state == RUN / state == HALT

module tiny_acc_core
    import tiny_acc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16,
    localparam int AW        = clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [INST_W-1:0] prog_data,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] acc_out,
    output logic [AW-1:0]     pc_out,
    output logic              running,
    output logic              halted
);

    state_e              state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [INST_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   dmem_q [DMEM_DEPTH];
    logic [INST_W-1:0]   imem_q [IMEM_DEPTH];

    logic [OP_W-1:0]     ir_op;
    logic [ARG_W-1:0]    ir_arg;
    logic [DATA_W-1:0]   sext_imm;
    logic [DATA_W-1:0]   rs_data;
    logic                rs_in_range;
    logic [DATA_W-1:0]   alu_result;
    logic [INST_W-1:0]   fetch_inst;
    logic [OP_W-1:0]     fetch_op;
    logic                advance;
    logic                imem_we;
    logic                dmem_we;

    assign ir_op    = ir_q[OP_LSB +: OP_W];
    assign ir_arg   = ir_q[ARG_LSB +: ARG_W];
    assign sext_imm = DATA_W'($signed(ir_arg));

    // dmem[rs] read; rs is a full nibble, so depths below 16 leave holes
    // that read as zero.
    always_comb begin
        rs_data     = '0;
        rs_in_range = 1'b0;
        for (int i = 0; i < DMEM_DEPTH; i++) begin
            if (ir_arg == 4'(i)) begin
                rs_data     = dmem_q[i];
                rs_in_range = 1'b1;
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        for (int i = 0; i < DMEM_DEPTH; i++) begin
            if (dbg_addr == 4'(i)) begin
                dbg_data = dmem_q[i];
            end
        end
    end

    tiny_acc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i       (ir_op),
        .acc_i      (acc_q),
        .operand_i  (rs_data),
        .sext_imm_i (sext_imm),
        .result_o   (alu_result)
    );

    assign fetch_inst = imem_q[pc_q];
    assign fetch_op   = fetch_inst[OP_LSB +: OP_W];

    // In step mode every non-step cycle is a full pipeline stall.
    assign advance = (state_q == ST_RUN) && (!step_mode || step);
    assign imem_we = prog_we && (state_q != ST_RUN);
    assign dmem_we = advance && (ir_op == OP_SA) && rs_in_range;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    ir_d    = INST_NOP;
                    acc_d   = '0;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    acc_d = alu_result;
                    if (ir_op == OP_HALT) begin
                        // HALT retires: freeze fetch so nothing younger runs.
                        state_d = ST_HALT;
                    end else if (fetch_op == OP_HALT) begin
                        // HALT enters IR but pc stays on it.
                        ir_d = fetch_inst;
                    end else begin
                        ir_d = fetch_inst;
                        // BNZ tests the forwarded result of the instruction
                        // executing alongside it, not the stale acc_q.
                        if ((fetch_op == OP_BNZ) && (alu_result != '0)) begin
                            pc_d = fetch_inst[ARG_LSB +: AW];
                        end else begin
                            pc_d = pc_q + AW'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= INST_NOP;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                if (dmem_we && (ir_arg == 4'(i))) begin
                    dmem_q[i] <= acc_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                imem_q[i] <= INST_HALT;
            end
        end else begin
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                if (imem_we && (prog_addr == AW'(i))) begin
                    imem_q[i] <= prog_data;
                end
            end
        end
    end

    assign acc_out = acc_q;
    assign pc_out  = pc_q;
    assign running = (state_q == ST_RUN);
    assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_tiny_acc_core.sv
module tb_tiny_acc_core;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       start;
    logic       step_mode;
    logic       step;
    logic [3:0] dbg_addr;

    logic [7:0]  dbg8, acc8;
    logic [3:0]  pc8;
    logic        running8, halted8;
    logic [15:0] dbg16, acc16;
    logic [3:0]  pc16;
    logic        running16, halted16;

    tiny_acc_core #(.DATA_W(8), .IMEM_DEPTH(16), .DMEM_DEPTH(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .step_mode(step_mode), .step(step),
        .dbg_addr(dbg_addr), .dbg_data(dbg8), .acc_out(acc8), .pc_out(pc8),
        .running(running8), .halted(halted8)
    );

    tiny_acc_core #(.DATA_W(16), .IMEM_DEPTH(16), .DMEM_DEPTH(12)) dut16 (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .step_mode(step_mode), .step(step),
        .dbg_addr(dbg_addr), .dbg_data(dbg16), .acc_out(acc16), .pc_out(pc16),
        .running(running16), .halted(halted16)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_acc_q[$];
    logic [3:0] exp_pc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3, input int n);
        logic [7:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < n; i++) begin
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = w[i];
            cycle();
        end
        prog_we = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        int c;
        c = 0;
        while (!halted8 && c < budget) begin
            cycle();
            c++;
        end
        check({tag, "_halted8"}, 32'(halted8), 32'd1);
        check({tag, "_halted16"}, 32'(halted16), 32'd1);
    endtask

    task automatic peek_dmem(input string tag, input logic [3:0] a,
                             input logic [31:0] e8, input logic [31:0] e16);
        dbg_addr = a;
        #1;
        check({tag, "_dbg8"}, 32'(dbg8), e8);
        check({tag, "_dbg16"}, 32'(dbg16), e16);
    endtask

    // Loop program: expected (acc, pc) after each advance.
    task automatic push_loop_model();
        logic [7:0] a [9];
        logic [3:0] p [9];
        a = '{8'd0, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
        p = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
        exp_acc_q.delete();
        exp_pc_q.delete();
        for (int i = 0; i < 9; i++) begin
            exp_acc_q.push_back(a[i]);
            exp_pc_q.push_back(p[i]);
        end
    endtask

    // period 1: free running; period N>1: step pulsed every Nth cycle.
    task automatic run_model(input string tag, input int period, input int budget);
        logic [7:0] cur_acc;
        logic [3:0] cur_pc;
        int  c;
        bit  adv;
        cur_acc = 8'h00;
        cur_pc  = 4'h0;
        c = 0;
        while (exp_acc_q.size() > 0 && c < budget) begin
            adv  = (period <= 1) || ((c % period) == period - 1);
            step = (period > 1) && adv;
            cycle();
            c++;
            if (adv) begin
                cur_acc = exp_acc_q.pop_front();
                cur_pc  = exp_pc_q.pop_front();
                check({tag, "_halted"}, 32'(halted8), 32'(exp_acc_q.size() == 0));
            end
            check({tag, adv ? "_acc" : "_stall_acc"}, 32'(acc8), 32'(cur_acc));
            check({tag, adv ? "_pc" : "_stall_pc"}, 32'(pc8), 32'(cur_pc));
        end
        step = 1'b0;
        check({tag, "_model_drained"}, 32'(exp_acc_q.size()), 32'd0);
        check({tag, "_acc16"}, 32'(acc16), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; step_mode = 1'b0; step = 1'b0; dbg_addr = '0;

        repeat (3) cycle();
        check("rst_acc", 32'(acc8), 32'd0);
        check("rst_pc", 32'(pc8), 32'd0);
        check("rst_running", 32'(running8), 32'd0);
        check("rst_halted", 32'(halted8), 32'd0);
        check("rst_acc16", 32'(acc16), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Empty imem is all HALT: halted exactly two cycles after start.
        start_pulse();
        check("empty_running", 32'(running8), 32'd1);
        check("empty_pc0", 32'(pc8), 32'd0);
        cycle();
        check("empty_not_yet", 32'(halted8), 32'd0);
        cycle();
        check("empty_halted", 32'(halted8), 32'd1);
        check("empty_running_off", 32'(running8), 32'd0);
        check("empty_acc", 32'(acc8), 32'd0);
        for (int i = 0; i < 16; i++) begin
            peek_dmem("empty_dmem", 4'(i), 32'd0, 32'd0);
        end

        // LI 5; SLLI 2; SA 3; HALT
        load_prog(8'h54, 8'h25, 8'h3F, 8'h07, 4);
        start_pulse();
        run_to_halt("p1", 20);
        check("p1_acc8", 32'(acc8), 32'h14);
        check("p1_acc16", 32'(acc16), 32'h14);
        peek_dmem("p1", 4'd3, 32'h14, 32'h14);

        // LI -8; SRLI 1; HALT  (logical shift)
        load_prog(8'h84, 8'h16, 8'h07, 8'h00, 3);
        exp_acc_q.delete();
        start_pulse();
        cycle();
        cycle();
        check("p2_li8", 32'(acc8), 32'hF8);
        check("p2_li16", 32'(acc16), 32'hFFF8);
        run_to_halt("p2", 20);
        check("p2_srl8", 32'(acc8), 32'h7C);
        check("p2_srl16", 32'(acc16), 32'h7FFC);

        // LI 3; ADDI -1; BNZ 1; HALT, free running then single-stepped
        load_prog(8'h34, 8'hF2, 8'h13, 8'h07, 4);
        push_loop_model();
        start_pulse();
        run_model("loop", 1, 40);
        check("loop_pc_final", 32'(pc8), 32'd3);

        step_mode = 1'b1;
        push_loop_model();
        start_pulse();
        run_model("step", 3, 100);
        step_mode = 1'b0;

        // Asynchronous reset in the middle of the loop.
        push_loop_model();
        start_pulse();
        repeat (4) cycle();
        check("mid_acc_before", 32'(acc8), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc", 32'(acc8), 32'd0);
        check("mid_rst_pc", 32'(pc8), 32'd0);
        check("mid_rst_running", 32'(running8), 32'd0);
        check("mid_rst_halted", 32'(halted8), 32'd0);
        peek_dmem("mid_rst", 4'd3, 32'd0, 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        start_pulse();
        cycle();
        cycle();
        check("post_rst_imem_halt", 32'(halted8), 32'd1);
        check("post_rst_acc", 32'(acc8), 32'd0);

        // prog_we while running must not touch imem.
        load_prog(8'h54, 8'h25, 8'h3F, 8'h07, 4);
        start_pulse();
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'h07;
        cycle();
        cycle();
        prog_we = 1'b0;
        run_to_halt("we_run1", 20);
        check("we_run1_acc", 32'(acc8), 32'h14);
        start_pulse();
        run_to_halt("we_run2", 20);
        check("we_run2_acc", 32'(acc8), 32'h14);

        // Write landing on the same edge as start is seen by the first fetch.
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h14;
        start_pulse();
        prog_we = 1'b0;
        run_to_halt("we_start", 20);
        check("we_start_acc8", 32'(acc8), 32'h04);
        check("we_start_acc16", 32'(acc16), 32'h04);

        // LI -1; SA 13; HALT: dut16 (12 words) drops the store.
        load_prog(8'hF4, 8'hDF, 8'h07, 8'h00, 3);
        start_pulse();
        run_to_halt("oob_sa", 20);
        check("oob_li8", 32'(acc8), 32'hFF);
        check("oob_li16", 32'(acc16), 32'hFFFF);
        peek_dmem("oob_sa", 4'd13, 32'hFF, 32'h0);

        // LI 4; LA 13; HALT: dut16 loads 0, dut8 reloads preserved 0xFF.
        load_prog(8'h44, 8'hDE, 8'h07, 8'h00, 3);
        start_pulse();
        run_to_halt("oob_la", 20);
        check("oob_la8", 32'(acc8), 32'hFF);
        check("oob_la16", 32'(acc16), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
